// File: rtl/dmem_stage.sv
// Data-memory stage: byte/half/word loads and stores on a little-endian,
// word-organised memory with per-byte write lanes and a registered read path.
module dmem_stage #(
   parameter int ADDR_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        rd_valid,
   output logic [31:0] rdata,
   output logic        fault
);

   localparam int DEPTH = 1 << ADDR_W;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Handshake: a request is taken on every rising edge with req_valid=1 and
   // rst=0; there is no backpressure, responses appear one edge later.

   logic [31:0]       mem_q [DEPTH];

   logic [ADDR_W-1:0] word_idx;
   logic [1:0]        lane;
   logic              unused_addr_hi;

   assign word_idx       = addr[ADDR_W+1:2];
   assign lane           = addr[1:0];
   assign unused_addr_hi = ^addr[31:ADDR_W+2];

   // ------------------------------------------------------------------
   // Request decode
   // ------------------------------------------------------------------
   logic is_load;
   logic is_store;
   logic load_f3_ok;
   logic store_f3_ok;
   logic aligned;
   logic req_fault;

   assign is_load  = req_valid &  mem_read & ~mem_write;
   assign is_store = req_valid &  mem_write & ~mem_read;

   always_comb begin
      load_f3_ok  = 1'b0;
      store_f3_ok = 1'b0;
      aligned     = 1'b1;
      unique case (funct3)
         F3_B: begin
            load_f3_ok  = 1'b1;
            store_f3_ok = 1'b1;
         end
         F3_H: begin
            load_f3_ok  = 1'b1;
            store_f3_ok = 1'b1;
            aligned     = ~addr[0];
         end
         F3_W: begin
            load_f3_ok  = 1'b1;
            store_f3_ok = 1'b1;
            aligned     = (addr[1:0] == 2'b00);
         end
         F3_BU: load_f3_ok = 1'b1;
         F3_HU: begin
            load_f3_ok = 1'b1;
            aligned    = ~addr[0];
         end
         default: ;
      endcase
   end

   // Both-or-neither of mem_read/mem_write is illegal, as is any bad size or alignment.
   assign req_fault = (req_valid & ~(is_load | is_store))
                    | (is_load  & ~(load_f3_ok  & aligned))
                    | (is_store & ~(store_f3_ok & aligned));

   // ------------------------------------------------------------------
   // Store path
   // ------------------------------------------------------------------
   logic [3:0]  wr_be;
   logic [31:0] wr_word;
   logic        wr_en;

   always_comb begin
      wr_be   = 4'b0000;
      wr_word = wdata;
      case (funct3)
         F3_B: begin
            wr_be   = 4'b0001 << lane;
            wr_word = {4{wdata[7:0]}};
         end
         F3_H: begin
            wr_be   = lane[1] ? 4'b1100 : 4'b0011;
            wr_word = {2{wdata[15:0]}};
         end
         F3_W: begin
            wr_be   = 4'b1111;
            wr_word = wdata;
         end
         default: ;
      endcase
   end

   assign wr_en = is_store & ~req_fault & ~rst;

   // Memory is deliberately left out of reset.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (wr_en && wr_be[b]) begin
            mem_q[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
         end
      end
   end

   // ------------------------------------------------------------------
   // Load path
   // ------------------------------------------------------------------
   logic [31:0] rd_word;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [31:0] load_ext;

   assign rd_word   = mem_q[word_idx];
   assign lane_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      lane_byte = rd_word[7:0];
      case (lane)
         2'd0: lane_byte = rd_word[7:0];
         2'd1: lane_byte = rd_word[15:8];
         2'd2: lane_byte = rd_word[23:16];
         2'd3: lane_byte = rd_word[31:24];
         default: ;
      endcase
   end

   always_comb begin
      load_ext = 32'h0;
      case (funct3)
         F3_B:  load_ext = {{24{lane_byte[7]}}, lane_byte};
         F3_BU: load_ext = {24'h0, lane_byte};
         F3_H:  load_ext = {{16{lane_half[15]}}, lane_half};
         F3_HU: load_ext = {16'h0, lane_half};
         F3_W:  load_ext = rd_word;
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Response registers
   // ------------------------------------------------------------------
   logic        rd_valid_q, rd_valid_d;
   logic [31:0] rdata_q,    rdata_d;
   logic        fault_q,    fault_d;

   always_comb begin
      rd_valid_d = is_load;
      fault_d    = req_fault;
      rdata_d    = rdata_q;
      if (is_load) begin
         rdata_d = req_fault ? 32'h0 : load_ext;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         rdata_q    <= 32'h0;
         fault_q    <= 1'b0;
      end else begin
         rd_valid_q <= rd_valid_d;
         rdata_q    <= rdata_d;
         fault_q    <= fault_d;
      end
   end

   assign rd_valid = rd_valid_q;
   assign rdata    = rdata_q;
   assign fault    = fault_q;

endmodule

// File: tb/tb_dmem_stage.sv
// Directed bench for dmem_stage: hand-computed load/store vectors covering
// lanes, extension, alignment faults, illegal requests, wrap-around and reset.
module tb_dmem_stage;

   localparam logic [2:0] F_B  = 3'b000;
   localparam logic [2:0] F_H  = 3'b001;
   localparam logic [2:0] F_W  = 3'b010;
   localparam logic [2:0] F_BU = 3'b100;
   localparam logic [2:0] F_HU = 3'b101;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        mem_read  = 1'b0;
   logic        mem_write = 1'b0;
   logic [2:0]  funct3    = 3'b000;
   logic [31:0] addr      = 32'h0;
   logic [31:0] wdata     = 32'h0;
   logic        rd_valid;
   logic [31:0] rdata;
   logic        fault;

   int n_chk = 0;
   int n_err = 0;

   dmem_stage #(.ADDR_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .funct3    (funct3),
      .addr      (addr),
      .wdata     (wdata),
      .rd_valid  (rd_valid),
      .rdata     (rdata),
      .fault     (fault)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic check_rsp(input string tag, input logic v, input logic [31:0] d, input logic f);
      check({tag, ".rd_valid"}, {31'h0, rd_valid}, {31'h0, v});
      check({tag, ".rdata"},    rdata,              d);
      check({tag, ".fault"},    {31'h0, fault},    {31'h0, f});
   endtask

   // ---------------- drivers ----------------
   // Presents one request for exactly one edge; outputs are sampled 1ns later.
   task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
      req_valid = 1'b1;
      mem_read  = rd;
      mem_write = wr;
      funct3    = f3;
      addr      = a;
      wdata     = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
   endtask

   task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      issue(1'b0, 1'b1, f3, a, wd);
   endtask

   task automatic load(input logic [2:0] f3, input logic [31:0] a);
      issue(1'b1, 1'b0, f3, a, 32'h0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      @(negedge clk);
      rst = 1'b1;
      tick();
      tick();
      check_rsp("reset", 1'b0, 32'h0, 1'b0);
      rst = 1'b0;

      // word store then load on the next edge
      store(F_W, 32'h10, 32'hDEADBEEF);
      check_rsp("sw_0x10", 1'b0, 32'h0, 1'b0);
      load(F_W, 32'h10);
      check_rsp("lw_0x10", 1'b1, 32'hDEADBEEF, 1'b0);
      tick();
      check_rsp("idle_hold", 1'b0, 32'hDEADBEEF, 1'b0);

      // byte lanes and extension
      store(F_W, 32'h20, 32'h0);
      store(F_B, 32'h23, 32'h80);
      load(F_W, 32'h20);
      check_rsp("lw_after_sb", 1'b1, 32'h80000000, 1'b0);
      load(F_B, 32'h23);
      check_rsp("lb_0x23", 1'b1, 32'hFFFFFF80, 1'b0);
      load(F_BU, 32'h23);
      check_rsp("lbu_0x23", 1'b1, 32'h00000080, 1'b0);
      store(F_H, 32'h20, 32'h1234F00D);
      load(F_W, 32'h20);
      check_rsp("lw_after_sh", 1'b1, 32'h8000F00D, 1'b0);
      load(F_H, 32'h22);
      check_rsp("lh_0x22", 1'b1, 32'hFFFF8000, 1'b0);
      load(F_HU, 32'h22);
      check_rsp("lhu_0x22", 1'b1, 32'h00008000, 1'b0);
      load(F_H, 32'h20);
      check_rsp("lh_0x20", 1'b1, 32'hFFFFF00D, 1'b0);
      load(F_B, 32'h21);
      check_rsp("lb_0x21", 1'b1, 32'hFFFFFFF0, 1'b0);
      load(F_BU, 32'h20);
      check_rsp("lbu_0x20", 1'b1, 32'h0000000D, 1'b0);

      // misalignment
      load(F_W, 32'h22);
      check_rsp("lw_misaligned", 1'b1, 32'h0, 1'b1);
      tick();
      check("fault_pulse_end", {31'h0, fault}, 32'h0);
      store(F_H, 32'h21, 32'hFFFF);
      check("sh_misaligned.fault", {31'h0, fault}, 32'h1);
      check("sh_misaligned.rd_valid", {31'h0, rd_valid}, 32'h0);
      load(F_W, 32'h20);
      check_rsp("lw_after_bad_sh", 1'b1, 32'h8000F00D, 1'b0);

      // illegal requests
      issue(1'b1, 1'b1, F_W, 32'h20, 32'h0);
      check("rd_and_wr.fault", {31'h0, fault}, 32'h1);
      tick();
      check("rd_and_wr.pulse_end", {31'h0, fault}, 32'h0);
      load(F_W, 32'h20);
      check_rsp("lw_after_rd_and_wr", 1'b1, 32'h8000F00D, 1'b0);
      store(F_BU, 32'h20, 32'h0);
      check("sw_f3_100.fault", {31'h0, fault}, 32'h1);
      check("sw_f3_100.rd_valid", {31'h0, rd_valid}, 32'h0);
      load(F_W, 32'h20);
      check_rsp("lw_after_bad_f3", 1'b1, 32'h8000F00D, 1'b0);
      issue(1'b0, 1'b0, F_W, 32'h20, 32'h0);
      check("no_rd_no_wr.fault", {31'h0, fault}, 32'h1);
      load(3'b011, 32'h20);
      check_rsp("load_f3_011", 1'b1, 32'h0, 1'b1);

      // back-to-back loads keep rd_valid high
      load(F_W, 32'h10);
      check_rsp("b2b_first", 1'b1, 32'hDEADBEEF, 1'b0);
      load(F_W, 32'h20);
      check_rsp("b2b_second", 1'b1, 32'h8000F00D, 1'b0);
      tick();
      check("b2b_drop", {31'h0, rd_valid}, 32'h0);

      // address wrap-around
      store(F_W, 32'h00000400, 32'hA5A5A5A5);
      load(F_W, 32'h0);
      check_rsp("wrap_lw_0", 1'b1, 32'hA5A5A5A5, 1'b0);

      // request on a reset edge is discarded
      store(F_W, 32'h30, 32'h11223344);
      rst = 1'b1;
      store(F_W, 32'h30, 32'h1);
      check_rsp("sw_during_rst", 1'b0, 32'h0, 1'b0);
      rst = 1'b0;
      load(F_W, 32'h30);
      check_rsp("lw_after_rst", 1'b1, 32'h11223344, 1'b0);

      // pending load response is cleared by a following reset edge
      load(F_W, 32'h10);
      check_rsp("lw_before_rst", 1'b1, 32'hDEADBEEF, 1'b0);
      rst = 1'b1;
      tick();
      check_rsp("rst_clears_rsp", 1'b0, 32'h0, 1'b0);
      rst = 1'b0;
      tick();
      check_rsp("post_rst_idle", 1'b0, 32'h0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
